freq_comp_mult: RTL
===================

// Module: freq_comp_mult
// PURPOSE
//  Reader side of the frequency-compensation ROM. Streams DFT output bins through a complex
//  multiply by per-bin compensation factors fetched from that ROM. The ROM is a pure
//  combinational read. Sits in postproc between the DFT core output and the output formatter.
//  One run per symbol: base_addr selects the DFT-size table, num_pts gives the bin count.
// PARAMETERS
//  DW        16    signed I/Q width of input and output samples
//  AW        14    ROM address width
//  CW        13    signed width of each factor half; rom_data = {re[25:13], im[12:0]}, Q1.11
//  FRAC      11    fractional bits of factor
//  ROM_DEPTH 9000  valid ROM entries (addresses 0..ROM_DEPTH-1)
// PORTS
//  clk        in   1     clock, rising edge
//  rst_n      in   1     synchronous reset, active low
//  start      in   1     1-cycle pulse: begin run (sampled only in IDLE)
//  base_addr  in   AW    ROM address of bin 0 factor
//  num_pts    in   AW    bins in this run, 0..ROM_DEPTH
//  busy       out  1     high from accepted start until done
//  done       out  1     1-cycle pulse at end of run
//  err_range  out  1     1-cycle pulse: start rejected, base_addr+num_pts > ROM_DEPTH
//  in_valid   in   1     input bin valid
//  in_ready   out  1     input bin accepted when in_valid & in_ready
//  in_re      in   DW    input real, signed
//  in_im      in   DW    input imag, signed
//  rom_addr   out  AW    address to compensation ROM
//  rom_data   in   2*CW  factor at rom_addr, same cycle
//  out_valid  out  1     output bin valid
//  out_ready  in   1     downstream accepts when out_valid & out_ready
//  out_re     out  DW    compensated real
//  out_im     out  DW    compensated imag
//  out_last   out  1     marks bin num_pts-1
// BEHAVIOUR
//  Reset: all outputs 0 (rom_addr=0); FSM IDLE; counters and pipeline valids cleared.
//    Reset mid-run aborts: no done, partial outputs discarded.
//  FSM IDLE->RUN: start & range ok & num_pts!=0. Latch base/num; busy=1 next cycle.
//  FSM IDLE->IDLE: start & num_pts==0 gives done pulse next cycle, busy stays 0.
//  FSM IDLE->IDLE: start & base_addr+num_pts>ROM_DEPTH (AW+1-bit sum) gives err_range pulse next cycle.
//  FSM RUN->DRAIN: after accepting bin num_pts-1.
//  FSM DRAIN->IDLE: on output handshake with out_last=1. done pulses that cycle+1; busy drops with done.
//  start outside IDLE is ignored.
//  Address: rom_addr = base+k, k = count of accepted bins. Advances only on input handshake.
//    Held at last address in DRAIN and at 0 in IDLE. No wrap.
//  stall = out_valid & ~out_ready; the whole pipeline freezes on stall.
//  in_ready = (state==RUN) & ~stall.
//  Pipeline, 3 stages:
//    S1 registers sample and rom_data together.
//    S2 registers the four products, each DW+CW bits.
//    S3 registers rounded/saturated result as out_*.
//  Latency: 3 cycles from input handshake to out_valid when unstalled. Throughput 1 bin/clk.
//  Arithmetic (re=a, im=b, factor c+jd):
//    pr = a*c - b*d, pi = a*d + b*c, DW+CW+1 bits, signed.
//    Add 2^(FRAC-1), arithmetic shift right FRAC (round half up).
//    Saturate to [-2^(DW-1), 2^(DW-1)-1].
//  out_last travels with bin num_pts-1. Out data and last hold stable while stalled.
//  Exactly num_pts output handshakes per run.
// TESTING
//  T1 base=100,num=4,factors 0x800/0 (1.0+0j), in (1000,-500) -> four outs (1000,-500), out_last on 4th, done after.
//  T2 factor 0/0x800 (0+1j), in (300,200) -> out (-200,300); latency exactly 3 clk with out_ready=1.
//  T3 in (32767,32767), factor (0xFFF,0xFFF) -> out_re=0 region ok, out_im saturates to 32767; (-32768,0)*(-2.0) -> 32767.
//  T4 out_ready low 5 cycles mid-run, num=8 -> in_ready low, outs held, all 8 delivered in order, no loss/dup.
//  T5 start base=8990,num=11 -> err_range pulse, busy 0; num=0 -> done pulse only; start while busy ignored.
//  T6 rst_n low mid-run after 3 bins -> all outputs 0 next clk, IDLE, no done; new run then works.

Source files
------------

// File: rtl/freq_comp_mult.sv
// Frequency-compensation multiplier: streams DFT bins through a complex multiply by
// per-bin factors read combinationally from the compensation ROM, three-stage pipeline.
module freq_comp_mult #(
    parameter int unsigned DW        = 16,
    parameter int unsigned AW        = 14,
    parameter int unsigned CW        = 13,
    parameter int unsigned FRAC      = 11,
    parameter int unsigned ROM_DEPTH = 9000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [AW-1:0]   base_addr,
    input  logic [AW-1:0]   num_pts,
    output logic            busy,
    output logic            done,
    output logic            err_range,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_re,
    input  logic [DW-1:0]   in_im,
    output logic [AW-1:0]   rom_addr,
    input  logic [2*CW-1:0] rom_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_re,
    output logic [DW-1:0]   out_im,
    output logic            out_last
);

    localparam int unsigned PW = DW + CW;
    localparam int unsigned RW = PW + 1;
    localparam logic signed [RW-1:0] MAXV  = RW'(2 ** (DW - 1) - 1);
    localparam logic signed [RW-1:0] MINV  = RW'(-(2 ** (DW - 1)));
    localparam logic signed [RW-1:0] RND   = RW'(2 ** (FRAC - 1));
    localparam logic [AW:0]          DEPTH = (AW + 1)'(ROM_DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e state_q, state_d;
    logic [AW-1:0] base_q, num_q, cnt_q;
    logic          done_q, err_q;

    logic                 s1_v_q, s1_last_q;
    logic signed [DW-1:0] s1_re_q, s1_im_q;
    logic signed [CW-1:0] s1_c_q, s1_d_q;
    logic                 s2_v_q, s2_last_q;
    logic signed [PW-1:0] p_ac_q, p_bd_q, p_ad_q, p_bc_q;
    logic                 out_valid_q, out_last_q;
    logic [DW-1:0]        out_re_q, out_im_q;

    logic stall, in_hs, out_hs, last_in, range_bad;
    logic start_run, start_zero, start_bad;
    logic [AW:0] sum;
    logic signed [RW-1:0] pr, pi, pr_sh, pi_sh;

    assign stall      = out_valid_q & ~out_ready;
    assign in_hs      = in_valid & in_ready;
    assign out_hs     = out_valid_q & out_ready;
    assign last_in    = (cnt_q == num_q - AW'(1));
    assign sum        = {1'b0, base_addr} + {1'b0, num_pts};
    assign range_bad  = (sum > DEPTH);
    assign start_bad  = (state_q == StIdle) & start & range_bad;
    assign start_zero = (state_q == StIdle) & start & ~range_bad & (num_pts == '0);
    assign start_run  = (state_q == StIdle) & start & ~range_bad & (num_pts != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_run) state_d = StRun;
            StRun:   if (in_hs && last_in) state_d = StDrain;
            StDrain: if (out_hs && out_last_q) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy     = (state_q != StIdle);
        in_ready = (state_q == StRun) & ~stall;
        unique case (state_q)
            StRun:   rom_addr = base_q + cnt_q;
            StDrain: rom_addr = base_q + cnt_q - AW'(1);
            default: rom_addr = '0;
        endcase
    end

    function automatic logic [DW-1:0] sat(input logic signed [RW-1:0] v);
        if (v > MAXV)      return MAXV[DW-1:0];
        else if (v < MINV) return MINV[DW-1:0];
        else               return v[DW-1:0];
    endfunction

    always_comb begin
        pr    = RW'(p_ac_q) - RW'(p_bd_q);
        pi    = RW'(p_ad_q) + RW'(p_bc_q);
        pr_sh = (pr + RND) >>> FRAC;
        pi_sh = (pi + RND) >>> FRAC;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_q      <= '0;
            num_q       <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            s1_v_q      <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_re_q     <= '0;
            s1_im_q     <= '0;
            s1_c_q      <= '0;
            s1_d_q      <= '0;
            s2_v_q      <= 1'b0;
            s2_last_q   <= 1'b0;
            p_ac_q      <= '0;
            p_bd_q      <= '0;
            p_ad_q      <= '0;
            p_bc_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
        end else begin
            done_q <= start_zero | ((state_q == StDrain) & out_hs & out_last_q);
            err_q  <= start_bad;
            if (start_run) begin
                base_q <= base_addr;
                num_q  <= num_pts;
                cnt_q  <= '0;
            end else if (in_hs) begin
                cnt_q <= cnt_q + AW'(1);
            end
            // Whole pipeline freezes while the output is stalled.
            if (!stall) begin
                s1_v_q      <= in_hs;
                s1_last_q   <= in_hs & last_in;
                s1_re_q     <= in_re;
                s1_im_q     <= in_im;
                s1_c_q      <= rom_data[2*CW-1:CW];
                s1_d_q      <= rom_data[CW-1:0];
                s2_v_q      <= s1_v_q;
                s2_last_q   <= s1_last_q;
                p_ac_q      <= PW'(s1_re_q) * PW'(s1_c_q);
                p_bd_q      <= PW'(s1_im_q) * PW'(s1_d_q);
                p_ad_q      <= PW'(s1_re_q) * PW'(s1_d_q);
                p_bc_q      <= PW'(s1_im_q) * PW'(s1_c_q);
                out_valid_q <= s2_v_q;
                out_last_q  <= s2_last_q;
                out_re_q    <= sat(pr_sh);
                out_im_q    <= sat(pi_sh);
            end
        end
    end

    assign done      = done_q;
    assign err_range = err_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;

endmodule
